// File: rtl/replay_buffer_ctrl.sv
// Ping-pong replay buffer sequencer: bank swap, write indexing
// and NUM_INPUTS-pass replay of the previous gamma's bank.
module replay_buffer_ctrl #(
  parameter  int BUFFER_DEPTH = 16,
  parameter  int NUM_INPUTS   = 2,
  localparam int IW = $clog2(BUFFER_DEPTH),
  localparam int SW = $clog2(NUM_INPUTS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_grst,
  input  logic          i_en,
  output logic          o_buf_sel,
  output logic          o_wr_en,
  output logic [IW-1:0] o_wr_idx,
  output logic          o_rd_valid,
  output logic [IW-1:0] o_rd_idx,
  output logic [SW-1:0] o_mux_sel,
  output logic          o_gamma_start,
  output logic          o_err_overrun,
  output logic          o_err_short
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(BUFFER_DEPTH - 1);
  localparam logic [SW-1:0] LAST_SEL = SW'(NUM_INPUTS - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [SW-1:0] ONE_SEL  = SW'(1);

  state_t        r_state;
  logic          r_grst_q;
  logic          r_buf_sel;
  logic          r_wr_en;
  logic [IW-1:0] r_wr_idx;
  logic          r_rd_valid;
  logic [IW-1:0] r_rd_idx;
  logic [SW-1:0] r_mux_sel;
  logic          r_gamma_start;
  logic          r_err_overrun;
  logic          r_err_short;

  logic w_gedge;
  logic w_wr_last;
  logic w_rd_last;
  logic w_rd_final;

  assign w_gedge    = i_grst & ~r_grst_q & i_en;
  assign w_wr_last  = (r_wr_idx == LAST_IDX);
  assign w_rd_last  = (r_rd_idx == LAST_IDX);
  assign w_rd_final = w_rd_last & (r_mux_sel == LAST_SEL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_grst_q      <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_idx      <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_idx      <= '0;
      r_mux_sel     <= '0;
      r_gamma_start <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_short   <= 1'b0;
    end else begin
      r_grst_q      <= i_grst;
      r_gamma_start <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_short   <= 1'b0;
      unique case (1'b1)
        !i_en: begin
          r_state    <= IDLE;
          r_wr_en    <= 1'b0;
          r_wr_idx   <= '0;
          r_rd_valid <= 1'b0;
          r_rd_idx   <= '0;
          r_mux_sel  <= '0;
        end
        w_gedge: begin
          r_buf_sel     <= ~r_buf_sel;
          r_wr_en       <= 1'b1;
          r_wr_idx      <= '0;
          r_rd_idx      <= '0;
          r_mux_sel     <= '0;
          r_gamma_start <= 1'b1;
          r_err_short   <= (r_state != IDLE) & r_wr_en & ~w_wr_last;
          r_err_overrun <= (r_state == RUN) & r_rd_valid & ~w_rd_final;
          // The read bank only holds valid data after one full FILL gamma.
          r_rd_valid    <= (r_state != IDLE);
          r_state       <= (r_state == IDLE) ? FILL : RUN;
        end
        default: begin
          if (r_wr_en) begin
            if (w_wr_last) begin
              r_wr_en  <= 1'b0;
              r_wr_idx <= '0;
            end else begin
              r_wr_idx <= r_wr_idx + ONE_IDX;
            end
          end
          if (r_rd_valid) begin
            if (w_rd_last) begin
              r_rd_idx <= '0;
              if (r_mux_sel == LAST_SEL) begin
                r_rd_valid <= 1'b0;
                r_mux_sel  <= '0;
              end else begin
                r_mux_sel <= r_mux_sel + ONE_SEL;
              end
            end else begin
              r_rd_idx <= r_rd_idx + ONE_IDX;
            end
          end
        end
      endcase
    end
  end

  assign o_buf_sel     = r_buf_sel;
  assign o_wr_en       = r_wr_en;
  assign o_wr_idx      = r_wr_idx;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_idx      = r_rd_idx;
  assign o_mux_sel     = r_mux_sel;
  assign o_gamma_start = r_gamma_start;
  assign o_err_overrun = r_err_overrun;
  assign o_err_short   = r_err_short;

endmodule

// File: tb/tb_replay_buffer_ctrl.sv
// Scoreboard bench for replay_buffer_ctrl (DEPTH=4, NUM=2):
// expected outputs derived from per-gamma cycle offsets.
module tb_replay_buffer_ctrl;

  localparam int D  = 4;
  localparam int N  = 2;
  localparam int IW = $clog2(D);
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          grst;
  logic          en;
  logic          buf_sel;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          rd_valid;
  logic [IW-1:0] rd_idx;
  logic [SW-1:0] mux_sel;
  logic          gamma_start;
  logic          err_overrun;
  logic          err_short;

  logic [10:0] w_obs;
  logic [10:0] sb[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   m_mode = 0;
  logic m_buf = 1'b0;
  int   m_prev_len = 0;

  replay_buffer_ctrl #(
    .BUFFER_DEPTH(D),
    .NUM_INPUTS  (N)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_grst       (grst),
    .i_en         (en),
    .o_buf_sel    (buf_sel),
    .o_wr_en      (wr_en),
    .o_wr_idx     (wr_idx),
    .o_rd_valid   (rd_valid),
    .o_rd_idx     (rd_idx),
    .o_mux_sel    (mux_sel),
    .o_gamma_start(gamma_start),
    .o_err_overrun(err_overrun),
    .o_err_short  (err_short)
  );

  always #5 clk = ~clk;

  assign w_obs = {buf_sel, wr_en, wr_idx, rd_valid,
                  rd_idx, mux_sel, gamma_start,
                  err_overrun, err_short};

  task automatic chk(string tag, logic [10:0] got,
                     logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] pk(
    logic bs, logic we, logic [1:0] wi, logic rv,
    logic [1:0] ri, logic ms, logic gs, logic eo,
    logic es);
    return {bs, we, wi, rv, ri, ms, gs, eo, es};
  endfunction

  task automatic step(string tag, logic g, logic e,
                      logic [10:0] exp);
    grst = g;
    en   = e;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      chk(tag, w_obs, sb.pop_front());
    end
  endtask

  task automatic gamma(int L, int hold = 1);
    logic       was_idle, was_run, eo, es;
    logic       we, rv;
    logic [1:0] wi, ri;
    logic       ms;
    was_idle = (m_mode == 0);
    was_run  = (m_mode == 2);
    eo = was_run && (m_prev_len < N * D);
    es = !was_idle && (m_prev_len < D);
    m_mode = was_idle ? 1 : 2;
    m_buf  = ~m_buf;
    for (int k = 0; k < L; k++) begin
      we = (k < D);
      wi = we ? 2'(k) : 2'd0;
      rv = (m_mode == 2) && (k < N * D);
      ri = rv ? 2'(k % D) : 2'd0;
      ms = rv ? 1'(k / D) : 1'b0;
      step($sformatf("g%0d_k%0d", L, k), k < hold, 1'b1,
           pk(m_buf, we, wi, rv, ri, ms, k == 0,
              (k == 0) && eo, (k == 0) && es));
    end
    m_prev_len = L;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step("idle", 1'b0, 1'b1, pk(m_buf, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic drop(logic g);
    m_mode = 0;
    step("drop", g, 1'b0, pk(m_buf, 0, 0, 0, 0, 0, 0, 0, 0));
    step("drop2", 1'b0, 1'b0, pk(m_buf, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    grst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", w_obs, 11'd0);
    rst = 1'b0;

    idle(50);
    gamma(8);
    gamma(8);
    gamma(12, 3);
    gamma(6);
    gamma(8);
    gamma(3);
    gamma(8);
    gamma(3);
    drop(1'b1);
    gamma(8);
    gamma(8);
    gamma(5);

    #1 rst = 1'b1;
    #1 chk("async_rst", w_obs, 11'd0);
    @(posedge clk);
    #1 chk("rst_hold", w_obs, 11'd0);
    #2 rst = 1'b0;
    grst = 1'b0;
    m_mode = 0;
    m_buf  = 1'b0;

    idle(2);
    gamma(8);
    gamma(8);
    gamma(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/replay_buffer_ctrl.md
# replay_buffer_ctrl

Sequencing controller for the multiplexed column's ping-pong replay buffer. Each gamma cycle it:
- swaps the write/read banks on the gamma boundary;
- drives the write index for the incoming spike stream;
- replays the previous gamma's bank once per multiplexed input (NUM_INPUTS passes), steering the output mux.

It sits between the gamma-reset generator and the replay buffer datapath, replacing free-running index logic. It flags gammas too short to complete a write or a replay.

## Interface
- BUFFER_DEPTH, 16: entries per bank; power of two, >= 2. IW = $clog2(BUFFER_DEPTH).
- NUM_INPUTS, 2: multiplexed input streams replayed per gamma, >= 2. SW = $clog2(NUM_INPUTS).

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- grst  in  1  gamma reset level, synchronous to clk; a sampled 0->1 transition marks a gamma boundary.
- en  in  1  controller enable (start_count); low forces IDLE.
- buf_sel  out  1  read bank select; write bank = ~buf_sel.
- wr_en  out  1  write strobe to the write bank.
- wr_idx  out  IW  write address.
- rd_valid  out  1  rd_idx/mux_sel present a valid replay sample.
- rd_idx  out  IW  read address.
- mux_sel  out  SW  input stream being replayed.
- gamma_start  out  1  one-cycle pulse, first cycle of each gamma.
- err_overrun  out  1  one-cycle pulse: gamma ended before replay finished.
- err_short  out  1  one-cycle pulse: gamma ended before write finished.

## Operation
- Edge detect: grst_q registers grst; gedge = grst & ~grst_q & en, evaluated at each posedge.
- All outputs are registered.
- States:
  - IDLE: no writes or reads.
  - FILL: first gamma after enabling; writes only, because the read bank holds nothing valid.
  - RUN: writes and replay both active.
- Transitions:
  - IDLE --gedge--> FILL.
  - FILL --gedge--> RUN.
  - RUN --gedge--> RUN, which restarts the gamma.
  - Any state --!en--> IDLE.
- On every gedge:
  - buf_sel toggles.
  - wr_en=1, wr_idx=0.
  - gamma_start=1.
  - In FILL entry: rd_valid=0.
  - In RUN entry: rd_valid=1, rd_idx=0, mux_sel=0.
- Write sequencing:
  - wr_idx increments each cycle while wr_en=1.
  - After the cycle presenting wr_idx=BUFFER_DEPTH-1, wr_en=0 and wr_idx=0; both hold until the next gedge.
- Read sequencing (RUN, rd_valid=1):
  - rd_idx increments each cycle.
  - At rd_idx=BUFFER_DEPTH-1: rd_idx wraps to 0 and mux_sel increments.
  - After (mux_sel=NUM_INPUTS-1, rd_idx=BUFFER_DEPTH-1): rd_valid=0, rd_idx=0, mux_sel=0, holding until the next gedge.
  - A full replay is NUM_INPUTS*BUFFER_DEPTH cycles.
- err_overrun: set in the cycle after a gedge taken in RUN while rd_valid=1 and the presented sample was not the final one (NUM_INPUTS-1, BUFFER_DEPTH-1). The replay is aborted.
- err_short: set in the cycle after a gedge taken in FILL/RUN while wr_en=1 and wr_idx != BUFFER_DEPTH-1. Unwritten entries keep stale data.
- A gedge presenting the final read/write sample is not an error.
- en low:
  - Next posedge: state=IDLE; wr_en, rd_valid, gamma_start and both err outputs = 0; indices = 0.
  - buf_sel holds.
  - Re-enable requires a gedge and re-enters FILL.
- Arithmetic: indices wrap modulo BUFFER_DEPTH and mux_sel modulo NUM_INPUTS. No wider intermediates.

## Timing
- Reset values: state=IDLE, buf_sel=0, wr_en=0, wr_idx=0, rd_valid=0, rd_idx=0, mux_sel=0, gamma_start=0, err_overrun=0, err_short=0, grst_q=0.
- Reset asserted mid-gamma clears all of these immediately, without waiting for clk.
- Latency: grst sampled high (grst_q=0) at posedge E. The new-gamma outputs are valid after E, so the first write/read sample is consumed at E+1.
- gamma_start, err_overrun and err_short are high for exactly one cycle, after E.
- A grst held high produces one gedge. Low-to-high again is needed for the next.
- gedge and en falling in the same cycle: en wins. Result is IDLE, no toggle, no pulses.
- Gamma of exactly NUM_INPUTS*BUFFER_DEPTH cycles: zero error pulses, rd_valid continuously high in RUN.

## Test plan
- Reset/idle: rst pulse mid-run (asynchronous, between clk edges) -> all outputs drop to reset values immediately. With en=1 and no grst edge for 50 cycles, outputs stay at reset values.
- Nominal (DEPTH=4, NUM=2, gamma = 8 cycles):
  - First gamma: buf_sel=1, wr_idx 0,1,2,3 then wr_en=0, rd_valid=0.
  - Second gamma: buf_sel=0, (mux_sel,rd_idx) = (0,0..3),(1,0..3).
  - No errors; gamma_start once per gamma.
- Long gamma (12 cycles): after 8 read cycles rd_valid=0 and rd_idx=mux_sel=0 for 4 cycles; no err pulses.
- Short gamma (6 cycles in RUN): err_overrun=1 for one cycle after the edge; replay restarts at (0,0).
- Short gamma (3 cycles): err_short=1 and err_overrun=1 together for one cycle; buf_sel still toggles.
- en dropped mid-RUN at wr_idx=2: next cycle IDLE, buf_sel held. Re-enable plus a grst edge enters FILL with rd_valid=0 and buf_sel toggled.
